data_ram_arbiter: RTL and testbench

- Shares the single data_ram port between two masters: M0, the CPU load/store port, and M1, a DMA or debug-loader port.
- Arbitration is combinational in the same cycle. Grant ownership and burst length are held in registers.
- Round-robin fairness is bounded by a burst limit. A master that is denied access is held by a stall output.
- Sits between openmips/loader and data_ram at the SOPC level.

---
 rtl/data_ram_arbiter.sv | 82 ++++++++
 tb/tb_data_ram_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/data_ram_arbiter.sv
// data_ram_arbiter: burst-limited round-robin arbiter sharing one data_ram port between two masters
// Ports: clk, rst (async active-low); m0_*/m1_* request buses (req/we/addr/sel/data in, gnt/stall out);
//        rd_data_o read data to both masters; ram_* outputs and ram_data_i to/from data_ram.
module data_ram_arbiter #(
    parameter int BURST_MAX = 4,
    parameter int AW        = 32,
    parameter int DW        = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_addr_i,
    input  logic [3:0]    m0_sel_i,
    input  logic [DW-1:0] m0_data_i,
    output logic          m0_gnt_o,
    output logic          m0_stall_o,
    input  logic          m1_req_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_addr_i,
    input  logic [3:0]    m1_sel_i,
    input  logic [DW-1:0] m1_data_i,
    output logic          m1_gnt_o,
    output logic          m1_stall_o,
    output logic [DW-1:0] rd_data_o,
    output logic          ram_ce_o,
    output logic          ram_we_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [3:0]    ram_sel_o,
    output logic [DW-1:0] ram_data_o,
    input  logic [DW-1:0] ram_data_i
);
    typedef enum logic [1:0] {OWN_NONE, OWN_M0, OWN_M1} owner_e;
    localparam logic [3:0] CNT_LAST = 4'(BURST_MAX - 1);
    owner_e     owner_q, owner_d;
    logic       last_q, last_d;
    logic [3:0] cnt_q, cnt_d;
    logic       g0, g1;
    // last_q is 1 when M1 was served last, so an idle tie goes to M0 exactly when last_q is set
    always_comb begin
        g0 = m0_req_i;
        g1 = m1_req_i;
        if (m0_req_i && m1_req_i) begin
            g0 = (owner_q == OWN_NONE) ? last_q :
                 (cnt_q < CNT_LAST)    ? (owner_q == OWN_M0) : (owner_q == OWN_M1);
            g1 = ~g0;
        end
        g0 = g0 & rst;
        g1 = g1 & rst;
    end
    always_comb begin
        owner_d = OWN_NONE;
        cnt_d   = '0;
        last_d  = last_q;
        if (g0 || g1) begin
            owner_d = g0 ? OWN_M0 : OWN_M1;
            last_d  = g1;
            cnt_d   = (owner_d != owner_q) ? 4'd0 : (cnt_q == CNT_LAST) ? cnt_q : cnt_q + 4'd1;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q <= OWN_NONE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end
    assign m0_gnt_o   = g0;
    assign m1_gnt_o   = g1;
    assign m0_stall_o = rst & m0_req_i & ~g0;
    assign m1_stall_o = rst & m1_req_i & ~g1;
    assign ram_ce_o   = g0 | g1;
    assign ram_we_o   = g0 ? m0_we_i   : g1 ? m1_we_i   : 1'b0;
    assign ram_addr_o = g0 ? m0_addr_i : g1 ? m1_addr_i : '0;
    assign ram_sel_o  = g0 ? m0_sel_i  : g1 ? m1_sel_i  : '0;
    assign ram_data_o = g0 ? m0_data_i : g1 ? m1_data_i : '0;
    assign rd_data_o  = rst ? ram_data_i : '0;
endmodule

// File: tb/tb_data_ram_arbiter.sv
// tb_data_ram_arbiter: table, directed and random checks of data_ram_arbiter against a run-length model
module tb_data_ram_arbiter;
    localparam int BM = 4;
    localparam logic [31:0] INIT = 32'hA5A50000;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic m0_req_i = 0, m0_we_i = 0, m1_req_i = 0, m1_we_i = 0;
    logic [31:0] m0_addr_i = 0, m0_data_i = 0, m1_addr_i = 0, m1_data_i = 0;
    logic [3:0] m0_sel_i = 0, m1_sel_i = 0;
    logic m0_gnt_o, m0_stall_o, m1_gnt_o, m1_stall_o, ram_ce_o, ram_we_o;
    logic [31:0] rd_data_o, ram_addr_o, ram_data_o, ram_data_i;
    logic [3:0] ram_sel_o;
    logic [31:0] mem [0:255] = '{default: INIT};
    logic [31:0] exp_mem [0:255] = '{default: INIT};
    int errors = 0, checks = 0;
    int holder, run, last;
    bit hold0, hold1;
    typedef struct {
        logic r0, r1, g0, g1;
    } vec_t;
    vec_t tv [$];

    data_ram_arbiter #(.BURST_MAX(BM), .AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i), .m0_sel_i(m0_sel_i),
        .m0_data_i(m0_data_i), .m0_gnt_o(m0_gnt_o), .m0_stall_o(m0_stall_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_sel_i(m1_sel_i),
        .m1_data_i(m1_data_i), .m1_gnt_o(m1_gnt_o), .m1_stall_o(m1_stall_o),
        .rd_data_o(rd_data_o), .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
        .ram_sel_o(ram_sel_o), .ram_data_o(ram_data_o), .ram_data_i(ram_data_i)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] d, logic [3:0] s);
        for (int b = 0; b < 4; b++) if (s[b]) o[8*b +: 8] = d[8*b +: 8];
        return o;
    endfunction

    // data_ram stand-in: combinational read, byte-lane write on the clock edge
    assign ram_data_i = mem[ram_addr_o[9:2]];
    always @(posedge clk) if (ram_ce_o && ram_we_o) mem[ram_addr_o[9:2]] <= merge(mem[ram_addr_o[9:2]], ram_data_o, ram_sel_o);

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // A master may keep the port for BM consecutive cycles while the other one waits;
    // with no previous holder, the master not served last wins the tie.
    function automatic int predict();
        if (!m0_req_i && !m1_req_i) return -1;
        if (m0_req_i != m1_req_i) return m0_req_i ? 0 : 1;
        if (holder < 0) return 1 - last;
        return (run < BM) ? holder : 1 - holder;
    endfunction

    task automatic model_reset();
        holder = -1;
        run = 0;
        last = 1;
    endtask

    task automatic settle_check();
        int g;
        logic [31:0] a;
        #2;
        g = predict();
        chk("gnt", {m0_gnt_o, m1_gnt_o}, {g == 0, g == 1});
        chk("stall", {m0_stall_o, m1_stall_o}, {m0_req_i && g != 0, m1_req_i && g != 1});
        chk("ce", ram_ce_o, g >= 0);
        if (g >= 0) begin
            a = (g == 0) ? m0_addr_i : m1_addr_i;
            chk("addr", ram_addr_o, a);
            chk("we", ram_we_o, (g == 0) ? m0_we_i : m1_we_i);
            if (ram_we_o) begin
                chk("wsel_wdata", {ram_sel_o, ram_data_o}, (g == 0) ? {m0_sel_i, m0_data_i} : {m1_sel_i, m1_data_i});
                exp_mem[a[9:2]] = (g == 0) ? merge(exp_mem[a[9:2]], m0_data_i, m0_sel_i) : merge(exp_mem[a[9:2]], m1_data_i, m1_sel_i);
            end else chk("rdata", rd_data_o, exp_mem[a[9:2]]);
            if (g == holder) run++;
            else begin
                holder = g;
                run = 1;
            end
            last = g;
        end else begin
            chk("idle_addr", ram_addr_o, 0);
            chk("idle_wsd", {ram_we_o, ram_sel_o, ram_data_o}, 0);
            holder = -1;
            run = 0;
        end
        hold0 = m0_req_i && g != 0;
        hold1 = m1_req_i && g != 1;
    endtask

    task automatic step();
        settle_check();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    initial begin
        int n;
        bit got;
        logic [31:0] saved;
        for (int i = 0; i < 12; i++) tv.push_back('{1, 1, (i < 4 || i >= 8), (i >= 4 && i < 8)});
        tv.push_back('{0, 0, 0, 0});
        for (int i = 0; i < 3; i++) tv.push_back('{1, 0, 1, 0});
        tv.push_back('{0, 1, 0, 1});
        for (int i = 0; i < 3; i++) tv.push_back('{1, 1, 0, 1});
        tv.push_back('{1, 1, 1, 0});
        model_reset();
        m0_req_i = 1;
        m1_req_i = 1;
        #7;
        chk("rst_gnt_stall_ce", {m0_gnt_o, m1_gnt_o, m0_stall_o, m1_stall_o, ram_ce_o, ram_we_o}, 0);
        chk("rst_rdata", rd_data_o, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1;
        foreach (tv[i]) begin
            m0_req_i = tv[i].r0;
            m1_req_i = tv[i].r1;
            settle_check();
            chk($sformatf("table%0d", i), {m0_gnt_o, m1_gnt_o}, {tv[i].g0, tv[i].g1});
            @(negedge clk);
        end
        m1_req_i = 0;
        {m0_req_i, m0_we_i, m0_addr_i, m0_sel_i, m0_data_i} = {1'b1, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF};
        step();
        m0_we_i = 0;
        settle_check();
        chk("m0_readback", rd_data_o, 32'hDEADBEEF);
        @(negedge clk);
        m0_req_i = 0;
        {m1_req_i, m1_we_i, m1_addr_i, m1_sel_i, m1_data_i} = {1'b1, 1'b1, 32'h100, 4'h3, 32'h12345678};
        step();
        m1_we_i = 0;
        settle_check();
        chk("m1_half_write", rd_data_o, 32'hDEAD5678);
        @(negedge clk);
        m1_addr_i = 32'h200;
        for (int i = 0; i < 20; i++) step();
        {m0_req_i, m0_we_i, m0_addr_i} = {1'b1, 1'b0, 32'h100};
        {m1_we_i, m1_addr_i, m1_sel_i, m1_data_i} = {1'b1, 32'h104, 4'hF, 32'hCAFEF00D};
        settle_check();
        chk("sat_m0_granted", {m0_gnt_o, m1_stall_o}, 2'b11);
        @(negedge clk);
        n = 0;
        got = 0;
        while (n < 8 && !got) begin
            settle_check();
            got = m1_gnt_o;
            if (!got) chk("held_not_written", mem[65], INIT);
            @(negedge clk);
            n++;
        end
        chk("m1_regranted", got, 1);
        chk("held_write_landed", mem[65], 32'hCAFEF00D);
        for (int i = 0; i < 400; i++) begin
            if (!hold0) begin
                m0_req_i = $urandom_range(0, 3) != 0;
                m0_we_i = $urandom_range(0, 1) != 0;
                m0_addr_i = 32'($urandom_range(0, 15)) << 2;
                m0_sel_i = 4'($urandom);
                m0_data_i = $urandom;
            end
            if (!hold1) begin
                m1_req_i = $urandom_range(0, 3) != 0;
                m1_we_i = $urandom_range(0, 1) != 0;
                m1_addr_i = 32'($urandom_range(0, 15)) << 2;
                m1_sel_i = 4'($urandom);
                m1_data_i = $urandom;
            end
            step();
        end
        m0_req_i = 0;
        {m1_req_i, m1_we_i, m1_addr_i, m1_sel_i, m1_data_i} = {1'b1, 1'b1, 32'h108, 4'hF, 32'h55AA55AA};
        saved = exp_mem[66];
        settle_check();
        chk("pre_rst_we", {m1_gnt_o, ram_we_o}, 2'b11);
        rst = 0;
        #1;
        chk("async_rst_we_drop", {m1_gnt_o, ram_ce_o, ram_we_o, m1_stall_o}, 0);
        @(posedge clk);
        #1;
        chk("async_rst_no_write", mem[66], saved);
        exp_mem[66] = saved;
        model_reset();
        @(negedge clk);
        rst = 1;
        {m0_req_i, m0_we_i, m0_addr_i} = {1'b1, 1'b0, 32'h100};
        m1_we_i = 0;
        settle_check();
        chk("post_rst_m0_first", {m0_gnt_o, m1_stall_o}, 2'b11);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
